// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared PC-source codes, fetch FSM states and default fetch addresses
package pc_pkg;

  localparam logic [1:0] PC_SRC_RESET = 2'b00;
  localparam logic [1:0] PC_SRC_ALU   = 2'b01;
  localparam logic [1:0] PC_SRC_PLUS4 = 2'b10;
  localparam logic [1:0] PC_SRC_HOLD  = 2'b11;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h4000_0000;
  localparam logic [31:0] DEFAULT_TRAP_PC  = 32'h4000_0100;

  // Wide enough for the largest legal flush length (7).
  localparam int FLUSH_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/flush_timer.sv
// rtl/flush_timer.sv - load/decrement counter that holds flush for FLUSH_CYCLES cycles
module flush_timer
  import pc_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic flush,
  output logic busy
);

  logic [FLUSH_CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      flush <= 1'b0;
    end else if (load) begin
      cnt   <= FLUSH_CNT_W'(FLUSH_CYCLES - 1);
      flush <= 1'b1;
    end else if (cnt != '0) begin
      cnt   <= cnt - 1'b1;
      flush <= 1'b1;
    end else begin
      flush <= 1'b0;
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - fetch PC sequencer (boot/+4/hold/redirect); MISALIGN_TRAP_EN enables misaligned-redirect trap
module pc_fetch_ctrl
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter logic [31:0] TRAP_PC      = DEFAULT_TRAP_PC,
  parameter int          FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] fetch_pc,
  output logic        fetch_valid,
  output logic        flush,
  output logic [1:0]  pc_src,
  output logic [15:0] redirect_cnt,
  output logic        misalign_trap
);

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_d;
  logic [1:0]   src_d;
  logic         valid_d;
  logic [15:0]  cnt_d;
  logic         trap_d;
  logic         accept;
  logic         misaligned;
  logic         timer_busy;

  assign misaligned = (redirect_target[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    pc_d    = fetch_pc;
    src_d   = pc_src;
    valid_d = fetch_valid;
    cnt_d   = redirect_cnt;
    trap_d  = 1'b0;
    accept  = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
        valid_d = 1'b1;
        pc_d    = RESET_PC;
        src_d   = PC_SRC_RESET;
      end
      default: begin
        valid_d = 1'b1;
        if (redirect_valid) begin
          // Redirect beats stall; a redirect in FLUSH restarts the timer.
          accept  = 1'b1;
          state_d = ST_FLUSH;
          src_d   = PC_SRC_ALU;
          trap_d  = TRAP_ON && misaligned;
          pc_d    = (TRAP_ON && misaligned) ? TRAP_PC : word_align(redirect_target);
          if (redirect_cnt != 16'hFFFF) cnt_d = redirect_cnt + 16'd1;
        end else begin
          if (stall) begin
            src_d = PC_SRC_HOLD;
          end else begin
            pc_d  = fetch_pc + 32'd4;
            src_d = PC_SRC_PLUS4;
          end
          if (state_q == ST_FLUSH && !timer_busy) state_d = ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      fetch_pc      <= RESET_PC;
      fetch_valid   <= 1'b0;
      pc_src        <= PC_SRC_RESET;
      redirect_cnt  <= 16'd0;
      misalign_trap <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc      <= pc_d;
      fetch_valid   <= valid_d;
      pc_src        <= src_d;
      redirect_cnt  <= cnt_d;
      misalign_trap <= trap_d;
    end
  end

  flush_timer #(
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) u_flush_timer (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .flush(flush),
    .busy (timer_busy)
  );

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - directed self-checking bench for pc_fetch_ctrl (flush length 1 and 3)
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;

  logic [31:0] fetch_pc, fetch_pc3;
  logic        fetch_valid, fetch_valid3;
  logic        flush, flush3;
  logic [1:0]  pc_src, pc_src3;
  logic [15:0] redirect_cnt, redirect_cnt3;
  logic        misalign_trap, misalign_trap3;

  int total = 0;
  int bad   = 0;

`ifdef MISALIGN_TRAP_EN
  localparam logic EXP_TRAP = 1'b1;
`else
  localparam logic EXP_TRAP = 1'b0;
`endif

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .fetch_pc(fetch_pc), .fetch_valid(fetch_valid), .flush(flush),
    .pc_src(pc_src), .redirect_cnt(redirect_cnt), .misalign_trap(misalign_trap)
  );

  pc_fetch_ctrl #(.FLUSH_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .fetch_pc(fetch_pc3), .fetch_valid(fetch_valid3), .flush(flush3),
    .pc_src(pc_src3), .redirect_cnt(redirect_cnt3), .misalign_trap(misalign_trap3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    tick(); tick(); tick();
    chk("rst_pc", fetch_pc, 32'h4000_0000);
    chk("rst_valid", {31'd0, fetch_valid}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_src", {30'd0, pc_src}, 32'd0);
    chk("rst_cnt", {16'd0, redirect_cnt}, 32'd0);
    chk("rst_trap", {31'd0, misalign_trap}, 32'd0);

    rst = 1'b0;
    tick();
    chk("boot_valid", {31'd0, fetch_valid}, 32'd1);
    chk("boot_pc", fetch_pc, 32'h4000_0000);
    chk("boot_src", {30'd0, pc_src}, 32'd0);
    tick();
    chk("seq1_pc", fetch_pc, 32'h4000_0004);
    chk("seq1_src", {30'd0, pc_src}, 32'd2);
    tick();
    chk("seq2_pc", fetch_pc, 32'h4000_0008);
    tick(); tick();
    chk("seq4_pc", fetch_pc, 32'h4000_0010);

    stall = 1'b1;
    tick();
    chk("stall1_pc", fetch_pc, 32'h4000_0010);
    chk("stall1_src", {30'd0, pc_src}, 32'd3);
    tick();
    chk("stall2_pc", fetch_pc, 32'h4000_0010);
    chk("stall2_src", {30'd0, pc_src}, 32'd3);

    redirect_valid = 1'b1; redirect_target = 32'h4000_0200;
    tick();
    chk("prio_pc", fetch_pc, 32'h4000_0200);
    chk("prio_src", {30'd0, pc_src}, 32'd1);
    chk("prio_flush", {31'd0, flush}, 32'd1);
    stall = 1'b0; redirect_valid = 1'b0;
    tick();
    chk("prio_flush_end", {31'd0, flush}, 32'd0);
    chk("prio_next_pc", fetch_pc, 32'h4000_0204);
    chk("prio_f3_still", {31'd0, flush3}, 32'd1);
    tick(); tick();
    chk("prio_f3_end", {31'd0, flush3}, 32'd0);

    redirect_valid = 1'b1; redirect_target = 32'h4000_0080;
    tick();
    redirect_valid = 1'b0;
    chk("f3_a_pc", fetch_pc3, 32'h4000_0080);
    chk("f3_a_fl", {31'd0, flush3}, 32'd1);
    tick();
    chk("f3_b_pc", fetch_pc3, 32'h4000_0084);
    chk("f3_b_fl", {31'd0, flush3}, 32'd1);
    tick();
    chk("f3_c_pc", fetch_pc3, 32'h4000_0088);
    chk("f3_c_fl", {31'd0, flush3}, 32'd1);
    tick();
    chk("f3_d_fl", {31'd0, flush3}, 32'd0);

    redirect_valid = 1'b1; redirect_target = 32'h4000_0080;
    tick();
    redirect_valid = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_target = 32'h4000_0300;
    tick();
    redirect_valid = 1'b0;
    chk("ext_pc", fetch_pc3, 32'h4000_0300);
    chk("ext_fl1", {31'd0, flush3}, 32'd1);
    chk("ext_trap", {31'd0, misalign_trap}, 32'd0);
    tick();
    chk("ext_fl2", {31'd0, flush3}, 32'd1);
    tick();
    chk("ext_fl3", {31'd0, flush3}, 32'd1);
    tick();
    chk("ext_fl4", {31'd0, flush3}, 32'd0);
    chk("ext_pc_end", fetch_pc3, 32'h4000_030C);
    chk("cnt_4", {16'd0, redirect_cnt}, 32'd4);

    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("wrap_top", fetch_pc, 32'hFFFF_FFFC);
    tick();
    chk("wrap_zero", fetch_pc, 32'h0000_0000);
    chk("wrap_src", {30'd0, pc_src}, 32'd2);

    redirect_valid = 1'b1; redirect_target = 32'h4000_0102;
    tick();
    redirect_valid = 1'b0;
    chk("mis_pc", fetch_pc, 32'h4000_0100);
    chk("mis_src", {30'd0, pc_src}, 32'd1);
    chk("mis_trap", {31'd0, misalign_trap}, {31'd0, EXP_TRAP});
    chk("mis_flush", {31'd0, flush}, 32'd1);
    chk("mis_cnt", {16'd0, redirect_cnt}, 32'd6);
    tick();
    chk("mis_trap_end", {31'd0, misalign_trap}, 32'd0);
    chk("mis_next_pc", fetch_pc, 32'h4000_0104);

    redirect_valid = 1'b1; redirect_target = 32'h4000_0080;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("mid_fl_before", {31'd0, flush3}, 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_fl", {31'd0, flush3}, 32'd0);
    chk("mid_rst_pc", fetch_pc3, 32'h4000_0000);
    chk("mid_rst_cnt", {16'd0, redirect_cnt3}, 32'd0);
    chk("mid_rst_valid", {31'd0, fetch_valid3}, 32'd0);
    chk("mid_rst_src", {30'd0, pc_src3}, 32'd0);
    rst = 1'b0;
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h4000_0800;
    tick();
    chk("boot_ign_pc", fetch_pc, 32'h4000_0000);
    chk("boot_ign_valid", {31'd0, fetch_valid}, 32'd1);
    chk("boot_ign_cnt", {16'd0, redirect_cnt}, 32'd0);
    stall = 1'b0;

    repeat (65534) tick();
    chk("sat_fffe", {16'd0, redirect_cnt}, 32'h0000_FFFE);
    tick();
    chk("sat_ffff", {16'd0, redirect_cnt}, 32'h0000_FFFF);
    repeat (5) tick();
    chk("sat_hold", {16'd0, redirect_cnt}, 32'h0000_FFFF);
    chk("sat_flush", {31'd0, flush}, 32'd1);
    redirect_valid = 1'b0;
    tick();
    chk("sat_flush_end", {31'd0, flush}, 32'd0);
    chk("sat_pc", fetch_pc, 32'h4000_0804);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Owns the architectural fetch PC and sequences next-PC selection: boot from reset, sequential +4, hold on stall, redirect on taken branch/jump.
- Sits between the execute-stage branch/jump resolution and instruction memory.
- Drives the IMEM address and front-end flush, and reports the chosen PC source on the team's 2-bit encoding.

Parameters:
- RESET_PC, 32'h4000_0000, first fetch address after reset.
- TRAP_PC, 32'h4000_0100, target substituted for misaligned redirects (used only with MISALIGN_TRAP_EN).
- FLUSH_CYCLES, 1, number of cycles flush stays high after an accepted redirect; legal range 1..7.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard/IMEM-busy hold request.
- redirect_valid  in  1  execute stage resolved taken branch or jump this cycle.
- redirect_target  in  32  ALU-computed target address.
- fetch_pc  out  32  registered IMEM fetch address.
- fetch_valid  out  1  fetch_pc is a real fetch (low during BOOT).
- flush  out  1  kill IF/ID contents.
- pc_src  out  2  selection made at last edge: 00 reset, 01 redirect, 10 pc+4, 11 hold.
- redirect_cnt  out  16  saturating count of accepted redirects (perf counter).
- misalign_trap  out  1  one-cycle pulse on misaligned redirect.

Behaviour:
- Reset (rst high at an edge), values after that edge:
  - fetch_pc = RESET_PC; fetch_valid = 0; flush = 0; pc_src = 00; redirect_cnt = 0; misalign_trap = 0; state = BOOT; flush counter = 0.
  - rst mid-operation aborts any flush immediately; reset overrides all inputs.
- States: BOOT, RUN, FLUSH. All outputs are registered; no combinational input-to-output path.
- BOOT:
  - Lasts exactly one cycle after rst deasserts; stall and redirect are ignored.
  - Next edge: state = RUN, fetch_valid = 1, fetch_pc stays RESET_PC, pc_src = 00.
- RUN and FLUSH, priority redirect > stall > sequential:
  - redirect_valid: fetch_pc <= redirect_target with bits [1:0] forced to 0; pc_src = 01; flush <= 1; flush counter <= FLUSH_CYCLES-1; state = FLUSH; redirect_cnt increments, saturating at 16'hFFFF.
  - stall (no redirect): fetch_pc holds; pc_src = 11; flush counter still decrements.
  - Otherwise: fetch_pc <= fetch_pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0); pc_src = 10.
- Latency: redirect sampled at edge t gives fetch_pc = target and flush = 1 after edge t; one bubble is killed.
- FLUSH:
  - flush stays high while counter != 0 at the edge; the counter decrements each edge.
  - When the counter is 0, next edge: flush = 0, state = RUN.
  - A redirect during FLUSH is accepted and restarts the counter.
- Simultaneous redirect and stall: redirect wins; the stall is dropped for that cycle.
- fetch_valid stays 1 in RUN and FLUSH. Consumers use flush to discard instructions.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: a redirect with target[1:0] != 0 loads fetch_pc = TRAP_PC instead of the target. misalign_trap pulses high for the one cycle after that edge. pc_src = 01, flush and redirect_cnt behave as for any redirect.
- Undefined: low bits are silently masked and misalign_trap is tied to 0.

Decomposition:
- Shared package pc_pkg holds:
  - PC_SRC_RESET=2'b00, PC_SRC_ALU=2'b01, PC_SRC_PLUS4=2'b10, PC_SRC_HOLD=2'b11.
  - State encoding.
  - Default RESET_PC/TRAP_PC constants, reused by the existing PC source decoder and the datapath mux.
- One natural sub-module: flush_timer (load/decrement counter emitting flush), sized by FLUSH_CYCLES.

Test Plan:
- Reset → boot: hold rst 3 cycles, release. Expected: fetch_pc = 32'h4000_0000 and fetch_valid = 0 for 1 cycle, then fetch_valid = 1. Next pcs are 4000_0004, 4000_0008 with pc_src = 10.
- Stall + redirect priority:
  - stall = 1 for 2 cycles at pc 4000_0010. Expected: pc holds, pc_src = 11.
  - Same-cycle redirect_valid with target 4000_0200. Expected: fetch_pc = 4000_0200, pc_src = 01, flush = 1 for 1 cycle.
- FLUSH_CYCLES=3:
  - Redirect to 4000_0080. Expected: flush high exactly 3 cycles, pc advances 0080→0084→0088.
  - Second redirect to 4000_0300 on the 2nd flush cycle. Expected: flush extends 3 more cycles.
- Wrap + saturation:
  - Force pc 32'hFFFF_FFFC without stall. Expected: next pc = 0.
  - Issue 65 540 redirects. Expected: redirect_cnt = 16'hFFFF.
- Misalign:
  - Macro defined, redirect to 4000_0102. Expected: fetch_pc = 4000_0100, misalign_trap pulses 1 cycle.
  - Macro undefined, same redirect. Expected: fetch_pc = 4000_0100, misalign_trap = 0.
- Reset mid-flush: rst during the 2nd flush cycle. Expected: next edge flush = 0, fetch_pc = RESET_PC, redirect_cnt = 0, state = BOOT.
